fft_radix2_core: RTL and testbench



---
 rtl/fft_radix2_core.sv | 145 ++++++++++++++
 tb/tb_fft_radix2_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_radix2_core.sv
// fft_radix2_core: in-place radix-2 DIT FFT/IFFT over N complex flop entries,
// bit-reversed load, one butterfly per cycle, natural-order unload.
module fft_radix2_core #(
    parameter int N_LOG2 = 3,
    parameter int DATA_W = 8,
    parameter int TW_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic inverse,
    output logic out_valid,
    input  logic out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [N_LOG2-1:0] out_idx,
    output logic busy
);
    localparam int N = 1 << N_LOG2;
    localparam int HW = N_LOG2 - 1;
    localparam int SW = $clog2(N_LOG2);
    localparam int PW = DATA_W + TW_W + 1;
    localparam int EW = DATA_W + 2;
    // cos(k*pi/32) * 2^24 for k = 0..16; every legal N samples this quarter wave
    localparam longint Q [17] = '{
        16777216, 16696429, 16454847, 16054795, 15500126, 14796184,
        13949745, 12968963, 11863283, 10643353, 9320922, 7908725,
        6420363, 4870169, 3273072, 1644455, 0
    };

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    state_t state, state_nx;

    logic [N_LOG2-1:0] in_cnt, wa, bfw, hm, jj, aa, bb;
    logic [SW-1:0] stage;
    logic [HW-1:0] bf, tt;
    logic inv, last_stage, last_bf;
    logic signed [DATA_W-1:0] mem_re [N];
    logic signed [DATA_W-1:0] mem_im [N];
    logic signed [TW_W-1:0] rom_re [N/2];
    logic signed [TW_W-1:0] rom_im [N/2];
    logic signed [DATA_W-1:0] ar, ai, br, bi;
    logic signed [TW_W-1:0] wr, wi;
    logic signed [PW-1:0] pr_f, pi_f;
    logic signed [EW-1:0] pr, pi, s0r, s0i, s1r, s1i;

    for (genvar i = 0; i < N/2; i++) begin : g_rom
        localparam int U = i * 64 / N;
        localparam longint C = Q[U <= 16 ? U : 32 - U];
        localparam longint S = Q[U <= 16 ? 16 - U : U - 16];
        localparam longint CR = (C * (2 ** (TW_W - 2)) + 8388608) >>> 24;
        localparam longint SR = (S * (2 ** (TW_W - 2)) + 8388608) >>> 24;
        assign rom_re[i] = TW_W'(U > 16 ? -CR : CR);
        assign rom_im[i] = TW_W'(-SR);
    end

    // halve with floor, then clamp the DATA_W+2 intermediate back to DATA_W
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [EW-1:0] v);
        logic signed [EW-1:0] h;
        h = v >>> 1;
        return (h[EW-1:DATA_W-1] == 3'b000 || h[EW-1:DATA_W-1] == 3'b111) ? h[DATA_W-1:0]
             : {h[EW-1], {(DATA_W-1){~h[EW-1]}}};
    endfunction

    always_comb begin
        wa = {<<{in_cnt}};
        bfw = {1'b0, bf};
        hm = N_LOG2'(1) << stage;
        jj = bfw & (hm - 1'b1);
        aa = ((bfw & ~(hm - 1'b1)) << 1) | jj;
        bb = aa | hm;
        tt = HW'(jj << (HW - 32'(stage)));
        ar = mem_re[aa];
        ai = mem_im[aa];
        br = mem_re[bb];
        bi = mem_im[bb];
        wr = rom_re[tt];
        wi = inv ? -rom_im[tt] : rom_im[tt];
        pr_f = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
        pi_f = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
        pr = EW'(pr_f >>> (TW_W - 2));
        pi = EW'(pi_f >>> (TW_W - 2));
        s0r = EW'(ar) + pr;
        s0i = EW'(ai) + pi;
        s1r = EW'(ar) - pr;
        s1i = EW'(ai) - pi;
    end

    assign last_stage = stage == SW'(N_LOG2 - 1);
    assign last_bf = last_stage && &bf;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= LOAD;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        in_ready = state == LOAD;
        busy = state == COMPUTE;
        out_valid = state == UNLOAD;
        state_nx = state == LOAD ? (in_valid && &in_cnt ? COMPUTE : LOAD)
                 : state == COMPUTE ? (last_bf ? UNLOAD : COMPUTE)
                 : (out_ready && &out_idx ? LOAD : UNLOAD);
        out_re = out_valid ? mem_re[out_idx] : '0;
        out_im = out_valid ? mem_im[out_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            in_cnt <= '0;
            stage <= '0;
            bf <= '0;
            out_idx <= '0;
            inv <= 1'b0;
        end else begin
            if (state == LOAD && in_valid) begin
                in_cnt <= in_cnt + 1'b1;
                if (in_cnt == '0) inv <= inverse;
            end
            if (state == COMPUTE) begin
                bf <= bf + 1'b1;
                if (&bf) stage <= last_stage ? '0 : stage + 1'b1;
            end
            if (state == UNLOAD && out_ready) out_idx <= out_idx + 1'b1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                mem_re[k] <= '0;
                mem_im[k] <= '0;
            end
        end else if (state == LOAD && in_valid) begin
            mem_re[wa] <= in_re;
            mem_im[wa] <= in_im;
        end else if (state == COMPUTE) begin
            mem_re[aa] <= sat(s0r);
            mem_im[aa] <= sat(s0i);
            mem_re[bb] <= sat(s1r);
            mem_im[bb] <= sat(s1i);
        end
endmodule

// File: tb/tb_fft_radix2_core.sv
// tb_fft_radix2_core: randomized frames against a plain-integer DIT FFT model,
// with hand-derived bins for impulse, DC, alternating and tone frames.
module tb_fft_radix2_core;
    localparam int N_LOG2 = 3;
    localparam int N = 1 << N_LOG2;
    localparam int DATA_W = 8;
    localparam int TW_W = 8;
    localparam int S = N_LOG2 * N / 2;
    localparam real PI = 3.14159265358979323846;
    localparam real ONE = 2.0 ** (TW_W - 2);

    logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, inverse = 1'b0, out_ready = 1'b0;
    logic [DATA_W-1:0] in_re = '0, in_im = '0;
    logic in_ready, out_valid, busy;
    logic [DATA_W-1:0] out_re, out_im;
    logic [N_LOG2-1:0] out_idx;

    int errors = 0, checks = 0;
    int xr[N], xi[N], yr[N], yi[N];
    int exp_re[1024], exp_im[1024], exp_idx[1024];
    int wr_ptr = 0, rd_ptr = 0;

    always #5 clk = ~clk;

    fft_radix2_core #(.N_LOG2(N_LOG2), .DATA_W(DATA_W), .TW_W(TW_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .inverse(inverse), .out_valid(out_valid),
        .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .busy(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rnd(input real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int sat(input int v);
        int hi = (1 << (DATA_W - 1)) - 1;
        return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
    endfunction

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < N_LOG2; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    function automatic void model(input bit inv);
        int ar[N], ai[N];
        int h, j, a, b, t, wr, wi, pr, pi, ta, tb;
        for (int k = 0; k < N; k++) begin
            ar[bitrev(k)] = xr[k];
            ai[bitrev(k)] = xi[k];
        end
        for (int s = 0; s < N_LOG2; s++)
            for (int bf = 0; bf < N / 2; bf++) begin
                h = 1 << s;
                j = bf % h;
                a = (bf / h) * 2 * h + j;
                b = a + h;
                t = j * N / (2 * h);
                wr = rnd(ONE * $cos(2.0 * PI * t / N));
                wi = -rnd(ONE * $sin(2.0 * PI * t / N));
                if (inv) wi = -wi;
                pr = (ar[b] * wr - ai[b] * wi) >>> (TW_W - 2);
                pi = (ar[b] * wi + ai[b] * wr) >>> (TW_W - 2);
                ta = ar[a];
                tb = ai[a];
                ar[a] = sat((ta + pr) >>> 1);
                ai[a] = sat((tb + pi) >>> 1);
                ar[b] = sat((ta - pr) >>> 1);
                ai[b] = sat((tb - pi) >>> 1);
            end
        for (int k = 0; k < N; k++) begin
            yr[k] = ar[k];
            yi[k] = ai[k];
        end
    endfunction

    task automatic push();
        for (int k = 0; k < N; k++) begin
            exp_re[wr_ptr % 1024] = yr[k];
            exp_im[wr_ptr % 1024] = yi[k];
            exp_idx[wr_ptr % 1024] = k;
            wr_ptr++;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!rst_n) rd_ptr = wr_ptr;
            else if (out_valid) begin
                if (rd_ptr == wr_ptr) check("spurious_out_valid", int'(out_valid), 0);
                else begin
                    check("out_re", $signed(out_re), exp_re[rd_ptr % 1024]);
                    check("out_im", $signed(out_im), exp_im[rd_ptr % 1024]);
                    check("out_idx", int'(out_idx), exp_idx[rd_ptr % 1024]);
                    if (out_ready) rd_ptr++;
                end
            end
        end
    endtask

    task automatic send(input bit inv, input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_re = DATA_W'($urandom);
                    in_im = DATA_W'($urandom);
                    inverse = ~inv;
                    @(posedge clk); #1;
                end
            in_valid = 1'b1;
            in_re = xr[k][DATA_W-1:0];
            in_im = xi[k][DATA_W-1:0];
            inverse = (k == 0) ? inv : ~inv;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("in_ready_drop", int'(in_ready), 0);
        check("busy_rise", int'(busy), 1);
    endtask

    task automatic latency(input bit noise);
        int n = 0;
        do begin
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_re = DATA_W'($urandom);
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 50);
        in_valid = 1'b0;
        check("out_valid_latency", n, S);
    endtask

    task automatic drain(input int mode, input bit noise);
        int n = 0, hold = 0;
        bit stalled = 1'b0;
        while (rd_ptr != wr_ptr && n < 200) begin
            if (mode == 2 && !stalled && out_idx == 3) begin
                stalled = 1'b1;
                hold = 5;
            end
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 3) != 0) : (hold == 0);
            if (hold > 0) hold--;
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("drain_done", int'(rd_ptr == wr_ptr), 1);
        check("in_ready_back", int'(in_ready), 1);
        check("out_valid_drop", int'(out_valid), 0);
    endtask

    task automatic run(input bit inv, input bit gaps, input int mode);
        model(inv);
        push();
        send(inv, gaps);
        latency(gaps);
        drain(mode, gaps);
    endtask

    task automatic clear_frame();
        for (int k = 0; k < N; k++) begin
            xr[k] = 0;
            xi[k] = 0;
        end
    endtask

    task automatic pin(input string name, input int k, input int er, input int ei);
        check(name, yr[k], er);
        check(name, yi[k], ei);
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_out_idx"}, int'(out_idx), 0);
        check({tag, "_out_re"}, int'(out_re), 0);
        check({tag, "_out_im"}, int'(out_im), 0);
    endtask

    initial begin
        fork compare_loop(); join_none
        #1 rst_n = 1'b0;
        #2 idle_checks("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        idle_checks("post_reset");

        clear_frame();
        xr[0] = 64;
        run(1'b0, 1'b0, 0);
        for (int k = 0; k < N; k++) pin("impulse_model", k, 8, 0);

        for (int k = 0; k < N; k++) xr[k] = 16;
        run(1'b0, 1'b0, 0);
        for (int k = 0; k < N; k++) pin("dc_model", k, k == 0 ? 16 : 0, 0);

        clear_frame();
        xr[4] = 64;
        run(1'b0, 1'b0, 0);
        for (int k = 0; k < N; k++) pin("alt_model", k, k % 2 ? -8 : 8, 0);

        clear_frame();
        xr[2] = 64;
        run(1'b0, 1'b0, 0);
        for (int k = 0; k < N; k++)
            pin("tone_fwd_model", k, k % 4 == 0 ? 8 : k % 4 == 2 ? -8 : 0,
                k % 4 == 1 ? -8 : k % 4 == 3 ? 8 : 0);
        run(1'b1, 1'b0, 0);
        for (int k = 0; k < N; k++)
            pin("tone_inv_model", k, k % 4 == 0 ? 8 : k % 4 == 2 ? -8 : 0,
                k % 4 == 1 ? 8 : k % 4 == 3 ? -8 : 0);

        clear_frame();
        xr[0] = 64;
        run(1'b0, 1'b1, 2);
        for (int k = 0; k < N; k++) pin("gaps_stall_model", k, 8, 0);

        clear_frame();
        xr[2] = 64;
        model(1'b0);
        push();
        send(1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 idle_checks("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle_checks("abort_release");
        clear_frame();
        xr[0] = 64;
        run(1'b0, 1'b0, 0);
        for (int k = 0; k < N; k++) pin("after_abort_model", k, 8, 0);

        for (int f = 0; f < 24; f++) begin
            for (int k = 0; k < N; k++) begin
                xr[k] = int'($urandom_range(0, 255)) - 128;
                xi[k] = int'($urandom_range(0, 255)) - 128;
            end
            run(1'($urandom_range(0, 1)), 1'b1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
